// File: rtl/qspi_fetch_seq.sv
// Fetch sequencer: turns 32-bit word fetch requests into the qspi_core register
// sequence (config once, load address, start, poll DONE, read data).
module qspi_fetch_seq #(
  parameter logic [23:0] CFG_ADDR   = 24'h000000,
  parameter logic [31:0] CFG_WORD   = 32'h0F208182,
  parameter logic [23:0] FADDR_ADDR = 24'h000004,
  parameter logic [23:0] CTRL_ADDR  = 24'h000014,
  parameter logic [31:0] START_WORD = 32'h00000004,
  parameter logic [23:0] STAT_ADDR  = 24'h000008,
  parameter logic [23:0] DATA_ADDR  = 24'h00000C,
  parameter logic [15:0] TIMEOUT    = 16'd1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [23:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        core_we_o,
  output logic        core_re_o,
  output logic [23:0] core_addr_o,
  output logic [31:0] core_wdata_o,
  input  logic [31:0] core_rdata_i
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_WADDR, S_START, S_POLL, S_PWAIT, S_RDATA, S_DWAIT, S_RSP
  } state_e;

  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  // armed_q is low only in the first cycle after reset, so the INIT write is
  // never driven while rst_ni is asserted and outputs stay zero in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      armed_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      state_q <= state_d;
      armed_q <= armed_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every signal assigned below gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d      = state_q;
    armed_d      = 1'b1;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    core_we_o    = 1'b0;
    core_re_o    = 1'b0;
    core_addr_o  = '0;
    core_wdata_o = '0;
    cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    unique case (state_q)
      S_INIT: begin
        if (armed_q) begin
          core_we_o    = 1'b1;
          core_addr_o  = CFG_ADDR;
          core_wdata_o = CFG_WORD;
          state_d      = S_IDLE;
        end
      end
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          state_d = S_WADDR;
        end
      end
      S_WADDR: begin
        core_we_o    = 1'b1;
        core_addr_o  = FADDR_ADDR;
        core_wdata_o = {8'h00, addr_q};
        state_d      = S_START;
      end
      S_START: begin
        core_we_o    = 1'b1;
        core_addr_o  = CTRL_ADDR;
        core_wdata_o = START_WORD;
        cnt_d        = '0;
        state_d      = S_POLL;
      end
      S_POLL: begin
        core_re_o   = 1'b1;
        core_addr_o = STAT_ADDR;
        state_d     = S_PWAIT;
      end
      S_PWAIT: begin
        // DONE wins over timeout when it shows up on the last allowed poll.
        if (core_rdata_i[0]) begin
          state_d = S_RDATA;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = S_RSP;
          end else begin
            state_d = S_POLL;
          end
        end
      end
      S_RDATA: begin
        core_re_o   = 1'b1;
        core_addr_o = DATA_ADDR;
        state_d     = S_DWAIT;
      end
      S_DWAIT: begin
        data_d  = core_rdata_i;
        err_d   = 1'b0;
        state_d = S_RSP;
      end
      S_RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign rsp_data_o = data_q;
  assign rsp_err_o  = err_q;

endmodule
